mul_div_iter: RTL and testbench

MUL_DIV_ITER -- requirements
Module: mul_div_iter

---
 rtl/mul_div_pkg.sv | 38 +++
 rtl/mul_div_iter_if.sv | 29 ++
 rtl/mul_div_sign_fix.sv | 24 ++
 rtl/mul_div_iter.sv | 140 ++++++++++++++
 tb/tb_mul_div_iter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared op codes, FSM states and helpers for the iterative mul/div unit
package mul_div_pkg;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULH  = 3'd1,
        OP_MULHU = 3'd2,
        OP_DIV   = 3'd3,
        OP_MOD   = 3'd4,
        OP_DIVU  = 3'd5,
        OP_MODU  = 3'd6,
        OP_NOP   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

    function automatic logic is_mul(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHU};
    endfunction

    function automatic logic is_div(input op_e op);
        return op inside {OP_DIV, OP_MOD, OP_DIVU, OP_MODU};
    endfunction

    function automatic logic is_signed(input op_e op);
        return op inside {OP_MULH, OP_DIV, OP_MOD};
    endfunction

endpackage

// File: rtl/mul_div_iter_if.sv
// mul_div_iter_if: request/response bundle of the iterative mul/div unit
interface mul_div_iter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] out_tag;
    logic             div_zero;
    logic             busy;

    modport master (
        output flush, in_valid, op, tag, a, b, out_ready,
        input  in_ready, out_valid, result, out_tag, div_zero, busy
    );

    modport slave (
        input  flush, in_valid, op, tag, a, b, out_ready,
        output in_ready, out_valid, result, out_tag, div_zero, busy
    );
endinterface

// File: rtl/mul_div_sign_fix.sv
// mul_div_sign_fix: operand magnitudes on accept and sign restoration of the raw results
module mul_div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               sgn_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   a_mag_o,
    output logic [WIDTH-1:0]   b_mag_o,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               sq_i,
    input  logic               sr_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quo_o,
    output logic [WIDTH-1:0]   rem_o
);
    always_comb begin
        a_mag_o = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag_o = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;
        prod_o  = sq_i ? -acc_i : acc_i;
        quo_o   = sq_i ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
        rem_o   = sr_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
    end
endmodule

// File: rtl/mul_div_iter.sv
// mul_div_iter: one-bit-per-cycle multiply/divide unit; define MUL_DIV_ZERO_BYPASS_EN to skip iterations on zero operands
module mul_div_iter
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_iter_if.slave io
);
    localparam int CW = cnt_w(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step;
    logic [WIDTH-1:0]   opnd_q, opnd_d, res_q, res_d, res_fix;
    op_e                op_q, op_d, op_in;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum, shf, diff;
    logic               accept;

    assign op_in  = op_e'(io.op);
    assign accept = io.in_valid && state_q == IDLE;

    mul_div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .sgn_i   (is_signed(op_in)),
        .a_i     (io.a),
        .b_i     (io.b),
        .a_mag_o (a_mag),
        .b_mag_o (b_mag),
        .acc_i   (acc_q),
        .sq_i    (sq_q),
        .sr_i    (sr_q),
        .prod_o  (prod),
        .quo_o   (quo),
        .rem_o   (rem)
    );

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shf  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff = shf - {1'b0, opnd_q};
        step = is_mul(op_q) ? {sum, acc_q[WIDTH-1:1]}
             : diff[WIDTH]  ? {shf[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
             :                {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        res_fix = (op_q == OP_MUL)                        ? prod[WIDTH-1:0]
                : (op_q == OP_MULH || op_q == OP_MULHU)   ? prod[2*WIDTH-1:WIDTH]
                : (op_q == OP_DIV  || op_q == OP_DIVU)    ? (dz_q ? '1 : quo)
                : (op_q == OP_MOD  || op_q == OP_MODU)    ? rem
                :                                           '0;
    end

`ifdef MUL_DIV_ZERO_BYPASS_EN
    logic byp;
    assign byp = (is_mul(op_in) && (io.a == '0 || io.b == '0)) ||
                 (is_div(op_in) && io.a == '0 && io.b != '0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        op_d    = op_q;
        tag_d   = tag_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d    = op_in;
                tag_d   = io.tag;
                sq_d    = is_signed(op_in) && (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
                sr_d    = is_signed(op_in) && io.a[WIDTH-1];
                dz_d    = is_div(op_in) && io.b == '0;
                acc_d   = {{WIDTH{1'b0}}, is_mul(op_in) ? b_mag : a_mag};
                opnd_d  = is_mul(op_in) ? a_mag : b_mag;
                cnt_d   = '0;
                state_d = CALC;
`ifdef MUL_DIV_ZERO_BYPASS_EN
                if (byp) begin
                    res_d   = '0;
                    state_d = DONE;
                end
`endif
            end
            CALC: begin
                acc_d   = step;
                cnt_d   = (cnt_q == CW'(WIDTH-1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : CALC;
            end
            FIX: begin
                res_d   = res_fix;
                state_d = DONE;
            end
            DONE: state_d = io.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (io.flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            op_q    <= OP_MUL;
            tag_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            dz_q    <= dz_d;
        end
    end

    assign io.in_ready  = state_q == IDLE;
    assign io.busy      = state_q != IDLE;
    assign io.out_valid = state_q == DONE;
    assign io.result    = res_q;
    assign io.out_tag   = tag_q;
    assign io.div_zero  = dz_q;
endmodule

// File: tb/tb_mul_div_iter.sv
// tb_mul_div_iter: directed self-checking bench for mul_div_iter at WIDTH=32
module tb_mul_div_iter;
    localparam int NORM_LAT = 34;
`ifdef MUL_DIV_ZERO_BYPASS_EN
    localparam int BYP_LAT = 1;
`else
    localparam int BYP_LAT = NORM_LAT;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mul_div_iter_if #(.WIDTH(32), .TAG_W(4)) io ();

    mul_div_iter #(.WIDTH(32), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (io.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tg, input logic [31:0] exp_r,
                         input logic exp_dz, input int exp_lat);
        int lat;
        io.in_valid = 1'b1;
        io.op = op;
        io.a = a;
        io.b = b;
        io.tag = tg;
        check({nm, "_in_ready"}, 64'(io.in_ready), 64'(1));
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        wait_valid(lat);
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_result"}, 64'(io.result), 64'(exp_r));
        check({nm, "_tag"}, 64'(io.out_tag), 64'(tg));
        check({nm, "_div_zero"}, 64'(io.div_zero), 64'(exp_dz));
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        check({nm, "_drop"}, 64'(io.out_valid), 64'(0));
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_in_ready"}, 64'(io.in_ready), 64'(1));
        check({nm, "_busy"}, 64'(io.busy), 64'(0));
        check({nm, "_out_valid"}, 64'(io.out_valid), 64'(0));
        check({nm, "_result"}, 64'(io.result), 64'(0));
        check({nm, "_out_tag"}, 64'(io.out_tag), 64'(0));
        check({nm, "_div_zero"}, 64'(io.div_zero), 64'(0));
    endtask

    initial begin
        int lat;
        int seen;
        io.flush = 1'b0;
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        io.op = 3'd0;
        io.tag = 4'd0;
        io.a = 32'd0;
        io.b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;

        do_op("mulh",    3'd1, 32'hFFFFFFFE, 32'h00000003, 4'd1,  32'hFFFFFFFF, 1'b0, NORM_LAT);
        do_op("mul",     3'd0, 32'hFFFFFFFE, 32'h00000003, 4'd2,  32'hFFFFFFFA, 1'b0, NORM_LAT);
        do_op("mulhu",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3,  32'hFFFFFFFE, 1'b0, NORM_LAT);
        do_op("div",     3'd3, 32'hFFFFFFF9, 32'h00000002, 4'd4,  32'hFFFFFFFD, 1'b0, NORM_LAT);
        do_op("mod",     3'd4, 32'hFFFFFFF9, 32'h00000002, 4'd5,  32'hFFFFFFFF, 1'b0, NORM_LAT);
        do_op("divu",    3'd5, 32'h00000007, 32'h00000002, 4'd6,  32'h00000003, 1'b0, NORM_LAT);
        do_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 4'd7,  32'h80000000, 1'b0, NORM_LAT);
        do_op("mod_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 4'd8,  32'h00000000, 1'b0, NORM_LAT);
        do_op("divu_z",  3'd5, 32'h00000005, 32'h00000000, 4'd9,  32'hFFFFFFFF, 1'b1, NORM_LAT);
        do_op("modu_z",  3'd6, 32'h00000005, 32'h00000000, 4'd10, 32'h00000005, 1'b1, NORM_LAT);
        do_op("div_z",   3'd3, 32'hFFFFFFF9, 32'h00000000, 4'd11, 32'hFFFFFFFF, 1'b1, NORM_LAT);
        do_op("mod_z",   3'd4, 32'hFFFFFFF9, 32'h00000000, 4'd12, 32'hFFFFFFF9, 1'b1, NORM_LAT);
        do_op("op7",     3'd7, 32'h00001234, 32'h00005678, 4'd13, 32'h00000000, 1'b0, NORM_LAT);
        do_op("mul_zero", 3'd0, 32'h00000000, 32'h00001234, 4'd14, 32'h00000000, 1'b0, BYP_LAT);
        do_op("div_zero_a", 3'd3, 32'h00000000, 32'h00000003, 4'd15, 32'h00000000, 1'b0, BYP_LAT);
        do_op("mul_nz",  3'd0, 32'h00000003, 32'h00000005, 4'd1,  32'h0000000F, 1'b0, NORM_LAT);

        // hold result under back-pressure, then offer a request alongside out_ready
        io.in_valid = 1'b1; io.op = 3'd0; io.a = 32'd3; io.b = 32'd4; io.tag = 4'd9;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        wait_valid(lat);
        check("hold_latency", 64'(lat), 64'(NORM_LAT));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(io.out_valid), 64'(1));
            check("hold_result", 64'(io.result), 64'(12));
            check("hold_tag", 64'(io.out_tag), 64'(9));
            check("hold_in_ready", 64'(io.in_ready), 64'(0));
        end
        io.out_ready = 1'b1;
        io.in_valid = 1'b1; io.op = 3'd5; io.a = 32'd100; io.b = 32'd7; io.tag = 4'd5;
        #1;
        check("same_cycle_in_ready", 64'(io.in_ready), 64'(0));
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        check("release_drop", 64'(io.out_valid), 64'(0));
        check("release_in_ready", 64'(io.in_ready), 64'(1));
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        check("next_accept_busy", 64'(io.busy), 64'(1));
        wait_valid(lat);
        check("next_accept_latency", 64'(lat), 64'(NORM_LAT));
        check("next_accept_result", 64'(io.result), 64'(14));
        check("next_accept_tag", 64'(io.out_tag), 64'(5));
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;

        // flush during the tenth CALC cycle
        io.in_valid = 1'b1; io.op = 3'd2; io.a = 32'hDEADBEEF; io.b = 32'h12345678; io.tag = 4'd6;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_pre_busy", 64'(io.busy), 64'(1));
        io.flush = 1'b1;
        @(posedge clk); #1;
        io.flush = 1'b0;
        check("flush_busy", 64'(io.busy), 64'(0));
        check("flush_in_ready", 64'(io.in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (io.out_valid === 1'b1) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'(0));

        // reset twenty cycles into an operation
        io.in_valid = 1'b1; io.op = 3'd3; io.a = 32'd1000; io.b = 32'd3; io.tag = 4'd7;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre_reset_tag", 64'(io.out_tag), 64'(7));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_vals("mid_reset");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (io.out_valid === 1'b1) seen++;
        end
        check("reset_no_valid", 64'(seen), 64'(0));

        do_op("post_reset_div", 3'd3, 32'd1000, 32'd3, 4'd2, 32'd333, 1'b0, NORM_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
